// File: rtl/assoc_dcache.sv
// assoc_dcache: write-back set-associative data cache with LRU replacement;
// halt flushes every dirty line and then stores the hit count to HIT_ADDR.
module assoc_dcache #(
    parameter int unsigned SETS     = 8,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned WORDS    = 2,
    parameter logic [31:0] HIT_ADDR = 32'h0000_3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);
    localparam int unsigned IW = $clog2(SETS);
    localparam int unsigned OW = $clog2(WORDS);
    localparam int unsigned AW = $clog2(WAYS);
    localparam int unsigned TW = 32 - IW - OW - 2;
    localparam logic [OW-1:0] LAST_W   = OW'(WORDS - 1);
    localparam logic [AW-1:0] LAST_WAY = AW'(WAYS - 1);
    localparam logic [IW-1:0] LAST_SET = IW'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, FETCH, FLUSH, CNT, DONE} state_t;

    state_t        state;
    logic          valid [SETS][WAYS];
    logic          dirty [SETS][WAYS];
    logic [TW-1:0] tags  [SETS][WAYS];
    logic [31:0]   data  [SETS][WAYS][WORDS];
    logic [AW-1:0] age   [SETS][WAYS];
    logic [31:0]   fbuf  [WORDS];
    logic [AW-1:0] victim;
    logic [OW-1:0] wcnt;
    logic [IW-1:0] fset;
    logic [AW-1:0] fway;
    logic [31:0]   hit_count;
    logic          miss;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [OW-1:0] req_off;
    logic          unused_byte_off;
    logic          req, hit, found_inv, start_flush, fetch_done, touch, flush_dirty;
    logic [AW-1:0] hit_way, new_victim, touch_way;

    assign req_tag         = dmemaddr[31 -: TW];
    assign req_idx         = dmemaddr[OW+2 +: IW];
    assign req_off         = dmemaddr[2 +: OW];
    assign unused_byte_off = ^dmemaddr[1:0];
    assign req             = dmemREN | dmemWEN;
    // A miss still owes its dhit, so halt waits until the miss flag clears.
    assign start_flush     = halt && !miss;
    assign dhit            = (state == IDLE) && req && hit && !start_flush;
    assign dmemload        = dhit ? data[req_idx][hit_way][req_off] : '0;
    assign flushed         = (state == DONE);
    assign fetch_done      = (state == FETCH) && !dwait && (wcnt == LAST_W);
    assign touch           = dhit || fetch_done;
    assign touch_way       = dhit ? hit_way : victim;
    assign flush_dirty     = valid[fset][fway] && dirty[fset][fway];

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        found_inv  = 1'b0;
        new_victim = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid[req_idx][w] && tags[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!found_inv && !valid[req_idx][w]) begin
                found_inv  = 1'b1;
                new_victim = AW'(w);
            end
        end
        if (!found_inv) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (age[req_idx][w] == LAST_WAY) new_victim = AW'(w);
            end
        end
    end

    always_comb begin
        dREN   = 1'b0;
        dWEN   = 1'b0;
        daddr  = '0;
        dstore = '0;
        case (state)
            WB: begin
                dWEN   = 1'b1;
                daddr  = {tags[req_idx][victim], req_idx, wcnt, 2'b00};
                dstore = data[req_idx][victim][wcnt];
            end
            FETCH: begin
                dREN  = 1'b1;
                daddr = {req_tag, req_idx, wcnt, 2'b00};
            end
            FLUSH: begin
                if (flush_dirty) begin
                    dWEN   = 1'b1;
                    daddr  = {tags[fset][fway], fset, wcnt, 2'b00};
                    dstore = data[fset][fway][wcnt];
                end
            end
            CNT: begin
                dWEN   = 1'b1;
                daddr  = HIT_ADDR;
                dstore = hit_count;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            victim    <= '0;
            wcnt      <= '0;
            fset      <= '0;
            fway      <= '0;
            hit_count <= '0;
            miss      <= 1'b0;
            for (int unsigned k = 0; k < WORDS; k++) fbuf[k] <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    valid[s][w] <= 1'b0;
                    dirty[s][w] <= 1'b0;
                    tags[s][w]  <= '0;
                    age[s][w]   <= AW'(w);
                    for (int unsigned k = 0; k < WORDS; k++) data[s][w][k] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (dhit) begin
                        if (miss) miss <= 1'b0;
                        else      hit_count <= hit_count + 32'd1;
                    end else if (start_flush) begin
                        state <= FLUSH;
                        fset  <= '0;
                        fway  <= '0;
                        wcnt  <= '0;
                    end else if (req) begin
                        victim <= new_victim;
                        miss   <= 1'b1;
                        wcnt   <= '0;
                        state  <= (valid[req_idx][new_victim] && dirty[req_idx][new_victim]) ? WB : FETCH;
                    end
                end
                WB: begin
                    if (!dwait) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_W) state <= FETCH;
                    end
                end
                FETCH: begin
                    if (!dwait) begin
                        fbuf[wcnt] <= dload;
                        wcnt       <= wcnt + 1'b1;
                    end
                    // Words are staged in fbuf so the line is replaced only once complete.
                    if (fetch_done) begin
                        for (int unsigned k = 0; k < WORDS; k++)
                            data[req_idx][victim][k] <= (OW'(k) == LAST_W) ? dload : fbuf[k];
                        valid[req_idx][victim] <= 1'b1;
                        dirty[req_idx][victim] <= 1'b0;
                        tags[req_idx][victim]  <= req_tag;
                        state                  <= IDLE;
                    end
                end
                FLUSH: begin
                    if (!flush_dirty || !dwait) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LAST_W) begin
                            valid[fset][fway] <= 1'b0;
                            dirty[fset][fway] <= 1'b0;
                            fway              <= fway + 1'b1;
                            if (fway == LAST_WAY) begin
                                fset <= fset + 1'b1;
                                if (fset == LAST_SET) state <= CNT;
                            end
                        end
                    end
                end
                CNT: begin
                    if (!dwait) state <= DONE;
                end
                default: ;
            endcase

            if (dhit && dmemWEN) begin
                data[req_idx][hit_way][req_off] <= dmemstore;
                dirty[req_idx][hit_way]         <= 1'b1;
            end

            if (touch) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (AW'(w) == touch_way)
                        age[req_idx][w] <= '0;
                    else if (age[req_idx][w] < age[req_idx][touch_way])
                        age[req_idx][w] <= age[req_idx][w] + 1'b1;
                end
            end
        end
    end
endmodule
